// File: rtl/alu_rr_arbiter.sv
// Round-robin front end for one shared combinational ALU: two requesters compete,
// the winner's operands are registered onto the ALU and its result returns tagged by id.
module alu_rr_arbiter #(
    parameter int WIDTH = 4,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_overflow,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   ptr;
    logic   grant0;
    logic   grant1;
    logic   rsp_hs;

    // ptr == 0 favours req0 on a tie; readies are held low while reset is asserted
    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!reset) begin
                    if (req0_valid && (!req1_valid || !ptr)) begin
                        grant0 = 1'b1;
                    end else if (req1_valid) begin
                        grant1 = 1'b1;
                    end
                end
                if (grant0 || grant1) begin
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = (state == RESP);
    assign rsp_hs     = rsp_valid && rsp_ready;
    assign busy       = (state == EXEC) || (state == RESP);

    // grant stage: operands onto the ALU; exec stage: capture result after one settle cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_opcode   <= '0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant0) begin
                alu_a      <= req0_a;
                alu_b      <= req0_b;
                alu_opcode <= req0_op;
                rsp_id     <= 1'b0;
            end else if (grant1) begin
                alu_a      <= req1_a;
                alu_b      <= req1_b;
                alu_opcode <= req1_op;
                rsp_id     <= 1'b1;
            end
            if (state == EXEC) begin
                rsp_result   <= alu_result;
                rsp_zero     <= alu_zero;
                rsp_overflow <= alu_overflow;
            end
            // the requester just served drops to lowest priority
            if (rsp_hs) begin
                ptr <= ~rsp_id;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a behavioural ALU and a response scoreboard.
module tb_alu_rr_arbiter;

    localparam int W   = 4;
    localparam int OPW = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0] req0_op, req1_op;
    logic [W-1:0]   alu_a, alu_b, alu_result;
    logic [OPW-1:0] alu_opcode;
    logic           alu_zero, alu_overflow;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_overflow, busy;
    logic [W-1:0]   rsp_result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base;

    typedef struct packed {
        logic         id;
        logic [W-1:0] res;
        logic         z;
        logic         v;
    } exp_t;

    exp_t     sb_q[$];
    int       grant_id[$];
    int       grant_cyc[$];
    int       rsp_ids[$];
    logic [W-1:0] rsp_res[$];
    int       rsp_cyc[$];

    always #5 clk = ~clk;

    alu_rr_arbiter #(.WIDTH(W), .OPW(OPW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
        .busy(busy)
    );

    // returns {zero, overflow, result}
    function automatic logic [W+1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [OPW-1:0] op);
        logic [W-1:0] r;
        logic         v;
        v = 1'b0;
        case (op)
            3'b000: begin r = a + b; v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
            3'b001: begin r = a - b; v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
            3'b010: r = a & b;
            3'b011: r = b[3] ? (a << b[2:0]) : (a >> b[2:0]);
            default: r = a | b;
        endcase
        return {(r == '0), v, r};
    endfunction

    always_comb {alu_zero, alu_overflow, alu_result} = alu_ref(alu_a, alu_b, alu_opcode);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb();
        logic [W+1:0] e;
        exp_t         x;
        chk("one_grant", {31'd0, req0_ready & req1_ready}, 32'd0);
        if (req0_valid && req0_ready) begin
            e = alu_ref(req0_a, req0_b, req0_op);
            sb_q.push_back({1'b0, e[W-1:0], e[W+1], e[W]});
            grant_id.push_back(0);
            grant_cyc.push_back(cyc - base);
        end
        if (req1_valid && req1_ready) begin
            e = alu_ref(req1_a, req1_b, req1_op);
            sb_q.push_back({1'b1, e[W-1:0], e[W+1], e[W]});
            grant_id.push_back(1);
            grant_cyc.push_back(cyc - base);
        end
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
            end else begin
                x = sb_q.pop_front();
                chk("sb_id", {31'd0, rsp_id}, {31'd0, x.id});
                chk("sb_result", {28'd0, rsp_result}, {28'd0, x.res});
                chk("sb_zero", {31'd0, rsp_zero}, {31'd0, x.z});
                chk("sb_ovf", {31'd0, rsp_overflow}, {31'd0, x.v});
            end
            rsp_ids.push_back(int'(rsp_id));
            rsp_res.push_back(rsp_result);
            rsp_cyc.push_back(cyc - base);
        end
    endtask

    task automatic nedge();
        @(negedge clk);
        sb();
    endtask

    task automatic pedge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_logs();
        grant_id.delete(); grant_cyc.delete();
        rsp_ids.delete(); rsp_res.delete(); rsp_cyc.delete();
        base = cyc;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pedge();
        pedge();
        reset = 1'b0;
    endtask

    initial begin
        base = 0;
        reset = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'b0110; req0_b = 4'b0011; req0_op = 3'b000;
        req1_valid = 1'b1; req1_a = 4'b0001; req1_b = 4'b0001; req1_op = 3'b000;

        // reset values, with both valids high to show readies are gated
        pedge(); pedge();
        nedge();
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_alu_a", {28'd0, alu_a}, 32'd0);
        chk("rst_alu_b", {28'd0, alu_b}, 32'd0);
        chk("rst_alu_op", {29'd0, alu_opcode}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_bits", {25'd0, rsp_id, rsp_result, rsp_zero, rsp_overflow}, 32'd0);
        pedge();

        // single request from req0
        req0_valid = 1'b1; req0_a = 4'b1010; req0_b = 4'b1001; req0_op = 3'b011;
        req1_valid = 1'b0;
        reset = 1'b0;
        nedge();
        chk("t1_req0_ready", {31'd0, req0_ready}, 32'd1);
        chk("t1_req1_ready", {31'd0, req1_ready}, 32'd0);
        pedge();
        req0_valid = 1'b0;
        nedge();
        chk("t1_alu_a", {28'd0, alu_a}, 32'b1010);
        chk("t1_alu_b", {28'd0, alu_b}, 32'b1001);
        chk("t1_alu_op", {29'd0, alu_opcode}, 32'b011);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
        pedge();
        nedge();
        chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t1_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("t1_rsp_result", {28'd0, rsp_result}, 32'b0100);
        chk("t1_rsp_zero", {31'd0, rsp_zero}, 32'd0);
        pedge();
        nedge();
        chk("t1_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);
        pedge();

        // simultaneous requests from reset alternate 0,1,0
        req0_valid = 1'b1; req0_a = 4'b1010; req0_b = 4'b0010; req0_op = 3'b011;
        req1_valid = 1'b1; req1_a = 4'b1001; req1_b = 4'b0001; req1_op = 3'b011;
        do_reset();
        clear_logs();
        for (int i = 0; i < 7; i++) begin nedge(); pedge(); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin nedge(); pedge(); end
        chk("t2_ngrants", grant_id.size(), 32'd3);
        chk("t2_grant0", grant_id[0], 32'd0);
        chk("t2_grant1", grant_id[1], 32'd1);
        chk("t2_grant2", grant_id[2], 32'd0);
        chk("t2_nrsp", rsp_ids.size(), 32'd3);
        chk("t2_rsp0_id", rsp_ids[0], 32'd0);
        chk("t2_rsp0_res", {28'd0, rsp_res[0]}, 32'b0010);
        chk("t2_rsp1_id", rsp_ids[1], 32'd1);
        chk("t2_rsp1_res", {28'd0, rsp_res[1]}, 32'b0100);

        // backpressure in RESP while req1 waits
        do_reset();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'b0011; req0_b = 4'b0000; req0_op = 3'b000;
        nedge();
        chk("t3_grant0", {31'd0, req0_ready}, 32'd1);
        pedge();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 4'b0101; req1_b = 4'b0011; req1_op = 3'b000;
        nedge();
        chk("t3_exec_req1_ready", {31'd0, req1_ready}, 32'd0);
        pedge();
        for (int i = 0; i < 5; i++) begin
            nedge();
            chk("t3_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t3_hold_result", {28'd0, rsp_result}, 32'b0011);
            chk("t3_hold_alu", {21'd0, alu_a, alu_b, alu_opcode}, {21'd0, 4'b0011, 4'b0000, 3'b000});
            chk("t3_hold_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
            chk("t3_hold_busy", {31'd0, busy}, 32'd1);
            pedge();
        end
        rsp_ready = 1'b1;
        nedge();
        pedge();
        nedge();
        chk("t3_req1_granted", {31'd0, req1_ready}, 32'd1);
        chk("t3_idle_busy", {31'd0, busy}, 32'd0);
        pedge();
        req1_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin nedge(); pedge(); end

        // zero flag from req1
        req1_valid = 1'b1; req1_a = 4'b0001; req1_b = 4'b0010; req1_op = 3'b011;
        nedge();
        chk("t4_req1_ready", {31'd0, req1_ready}, 32'd1);
        pedge();
        req1_valid = 1'b0;
        nedge(); pedge();
        nedge();
        chk("t4_rsp_result", {28'd0, rsp_result}, 32'b0000);
        chk("t4_rsp_zero", {31'd0, rsp_zero}, 32'd1);
        chk("t4_rsp_id", {31'd0, rsp_id}, 32'd1);
        pedge();

        // serve req0 so the pointer favours req1, then reset during EXEC
        req0_valid = 1'b1; req0_a = 4'b0111; req0_b = 4'b0001; req0_op = 3'b000;
        nedge(); pedge();
        req0_valid = 1'b0;
        nedge(); pedge();
        nedge(); pedge();
        req0_valid = 1'b1; req0_a = 4'b0110; req0_b = 4'b0001; req0_op = 3'b001;
        nedge(); pedge();
        req0_valid = 1'b0;
        reset = 1'b1;
        nedge();
        chk("t5_exec_busy", {31'd0, busy}, 32'd1);
        pedge();
        chk("t5_dropped_pending", sb_q.size(), 32'd1);
        sb_q.delete();
        reset = 1'b0;
        req0_valid = 1'b1; req0_a = 4'b0010; req0_b = 4'b0011; req0_op = 3'b010;
        req1_valid = 1'b1; req1_a = 4'b0100; req1_b = 4'b0010; req1_op = 3'b100;
        clear_logs();
        for (int i = 0; i < 7; i++) begin
            nedge();
            if (i == 0) begin
                chk("t5_no_rsp", {31'd0, rsp_valid}, 32'd0);
                chk("t5_busy", {31'd0, busy}, 32'd0);
                chk("t5_alu_op", {29'd0, alu_opcode}, 32'd0);
                chk("t5_ptr_req0_first", {30'd0, req0_ready, req1_ready}, 32'b10);
            end
            pedge();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin nedge(); pedge(); end
        chk("t5_ngrants", grant_id.size(), 32'd3);
        chk("t5_order", {29'd0, grant_id[0][0], grant_id[1][0], grant_id[2][0]}, 32'b010);

        // back-to-back single requester
        req0_valid = 1'b1; req0_a = 4'b1100; req0_b = 4'b1010; req0_op = 3'b011;
        clear_logs();
        for (int i = 0; i < 9; i++) begin
            nedge();
            pedge();
            if (i == 6) req0_valid = 1'b0;
        end
        chk("t6_ngrants", grant_cyc.size(), 32'd3);
        chk("t6_grant_c0", grant_cyc[0], 32'd0);
        chk("t6_grant_c1", grant_cyc[1], 32'd3);
        chk("t6_grant_c2", grant_cyc[2], 32'd6);
        chk("t6_nrsp", rsp_cyc.size(), 32'd3);
        chk("t6_rsp_c0", rsp_cyc[0], 32'd2);
        chk("t6_rsp_c1", rsp_cyc[1], 32'd5);
        chk("t6_rsp_c2", rsp_cyc[2], 32'd8);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares the single combinational ALU between two independent requesters, req0 and req1.
- Arbitrates round-robin, registers the winning operands onto the ALU inputs and captures result and flags after one settle cycle.
- Returns the captured result, tagged with the requester id, over a valid/ready response channel.
- Sits between the control FSMs (requesters) and the ALU instance. The ALU itself stays outside the block.

Parameters:
- WIDTH, 4, operand/result width; matches ALU A/B/result.
- OPW, 3, opcode width; matches ALU opcode.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous active-high reset
- req0_valid  input  1  requester 0 has a command
- req0_ready  output  1  requester 0 command accepted this cycle
- req0_a  input  WIDTH  operand A
- req0_b  input  WIDTH  operand B (for shift op 011: B[3]=1 left, 0 right; B[2:0]=amount)
- req0_op  input  OPW  ALU opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same directions/widths as requester 0
- alu_a  output  WIDTH  to ALU A
- alu_b  output  WIDTH  to ALU B
- alu_opcode  output  OPW  to ALU opcode
- alu_result  input  WIDTH  from ALU result
- alu_zero  input  1  from ALU zeroFlag
- alu_overflow  input  1  from ALU overflowFlag
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer takes response
- rsp_id  output  1  requester that issued the command (0/1)
- rsp_result  output  WIDTH  captured ALU result
- rsp_zero  output  1  captured zero flag
- rsp_overflow  output  1  captured overflow flag
- busy  output  1  high in EXEC or RESP

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). Polarity and synchronicity are fixed.
- Reset values:
  - State IDLE; priority pointer = 0 (req0 favoured).
  - alu_a = alu_b = 0, alu_opcode = 000.
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_zero = 0, rsp_overflow = 0.
  - busy = 0; both readies = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - The readies are combinational and asserted only in IDLE.
  - If exactly one valid is high, that requester wins.
  - If both are high, the pointer's requester wins.
  - Winner's ready = 1 for that cycle; the loser's ready = 0.
  - On the clock edge: latch a/b/op into alu_a/alu_b/alu_opcode, latch the id, go to EXEC.
  - No valid high: stay in IDLE; ALU outputs hold their last values.
- EXEC (one cycle): ALU inputs are stable. At the end of the cycle capture alu_result/alu_zero/alu_overflow into rsp_*, set rsp_valid = 1, go to RESP.
- RESP:
  - rsp_valid = 1; all rsp_* and alu_* remain stable until rsp_valid && rsp_ready.
  - On handshake: rsp_valid -> 0 next cycle, state -> IDLE, pointer <= ~rsp_id (the served requester becomes lowest priority).
  - No new grant is issued in the handshake cycle.
- Latency: command accepted in cycle t -> rsp_valid high from cycle t+2.
- Throughput: at most one command per 3 cycles with rsp_ready held high.
- Requester rule: a requester must hold valid and its fields stable until ready. A requester that is not granted sees ready = 0 and is not lost.
- Pointer update: only on the response handshake, never on grant.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...
- rsp_ready high outside RESP: ignored.
- Reset mid-operation (EXEC or RESP): transaction dropped, no response produced; next cycle IDLE with all reset values, pointer = 0.
- Opcode: passed through unmodified. The block does not decode ops.

Test Plan:
1. Single request: after reset, req0 a=1010 b=1001 op=011 valid at cycle 0, rsp_ready=1 -> req0_ready=1 in cycle 0; alu_a=1010/alu_b=1001 from cycle 1; rsp_valid in cycle 2 with rsp_id=0, rsp_result=0100, zero=0.
2. Simultaneous requests: both valid from reset, req0 a=1010 b=0010 op=011, req1 a=1001 b=0001 op=011.
   - First response: id=0, result 0010.
   - Second response: id=1, result 0100.
   - Grants alternate 0,1,0 while both stay valid.
3. Backpressure: rsp_ready=0 for 5 cycles in RESP while req1 valid -> rsp_valid, rsp_result and alu_* stable; req0_ready=req1_ready=0; busy=1. rsp_ready=1 -> IDLE next cycle, req1 granted the following IDLE cycle.
4. Zero flag: req1 a=0001 b=0010 op=011 -> rsp_result=0000, rsp_zero=1, rsp_id=1.
5. Reset mid-op: assert reset during EXEC -> rsp_valid never rises for that command; next cycle busy=0, alu_opcode=000, pointer=0. Simultaneous requests afterwards grant req0 first.
6. Back-to-back single requester: req0 continuously valid, rsp_ready=1 -> grants in cycles 0, 3, 6; responses in cycles 2, 5, 8.
